// File: rtl/pipelined_add_sub.sv
// Pipelined two's-complement adder/subtractor. The WIDTH-bit operation is split into
// STAGES equal slices; each stage resolves one slice and registers its carry-out.
module pipelined_add_sub #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             zero
);
    localparam int SL = WIDTH / STAGES;

    logic             advance;
    logic [WIDTH-1:0] b_eff;
    logic             overflow_q;
    logic             zero_q;

    // The whole pipe moves as one; a held output freezes every stage.
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;
    assign b_eff    = sub ? ~op2 : op2;

    for (genvar k = 0; k < STAGES; k++) begin : stg
        localparam int IW = WIDTH - k * SL;

        logic [IW-1:0]    a_in;
        logic [IW-1:0]    b_in;
        logic             c_in;
        logic             v_in;
        logic [WIDTH-1:0] s_in;
        logic [WIDTH-1:0] s_d;
        logic [WIDTH-1:0] s_q;
        logic [SL:0]      slice_sum;
        logic             v_q;
        logic             c_q;

        if (k == 0) begin : src
            assign a_in = op1;
            assign b_in = b_eff;
            assign c_in = sub | cin;
            assign v_in = in_valid & advance;
            assign s_in = '0;
        end else begin : src
            assign a_in = stg[k-1].fwd.a_q;
            assign b_in = stg[k-1].fwd.b_q;
            assign c_in = stg[k-1].c_q;
            assign v_in = stg[k-1].v_q;
            assign s_in = stg[k-1].s_q;
        end

        assign slice_sum = {1'b0, a_in[SL-1:0]} + {1'b0, b_in[SL-1:0]} + {{SL{1'b0}}, c_in};
        assign s_d       = s_in | (WIDTH'(slice_sum[SL-1:0]) << (k * SL));

        always_ff @(posedge CLK or negedge RESET_N) begin
            if (!RESET_N) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
            end else if (advance) begin
                v_q <= v_in;
                c_q <= slice_sum[SL];
                s_q <= s_d;
            end
        end

        // Operand bits not yet consumed travel alongside the partial sum.
        if (k < STAGES - 1) begin : fwd
            logic [IW-SL-1:0] a_q;
            logic [IW-SL-1:0] b_q;

            always_ff @(posedge CLK or negedge RESET_N) begin
                if (!RESET_N) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (advance) begin
                    a_q <= a_in[IW-1:SL];
                    b_q <= b_in[IW-1:SL];
                end
            end
        end

        if (k == STAGES - 1) begin : fin
            logic msb_cin;

            // Carry into the MSB recovered from the MSB sum bit and its operands.
            assign msb_cin = a_in[SL-1] ^ b_in[SL-1] ^ slice_sum[SL-1];

            always_ff @(posedge CLK or negedge RESET_N) begin
                if (!RESET_N) begin
                    overflow_q <= 1'b0;
                    zero_q     <= 1'b0;
                end else if (advance) begin
                    overflow_q <= msb_cin ^ slice_sum[SL];
                    zero_q     <= (s_d == '0);
                end
            end
        end
    end

    assign out_valid = stg[STAGES-1].v_q;
    assign result    = stg[STAGES-1].s_q;
    assign carry     = stg[STAGES-1].c_q;
    assign overflow  = overflow_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Bench for pipelined_add_sub: directed vectors at (8,2), backpressure at (16,4),
// reset mid-flight, and a random sweep at (8,1), (8,8), (32,4) against a reference model.
module tb_pipelined_add_sub;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc_n = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Returns {zero, overflow, carry, result[31:0]} for a w-bit operation.
    function automatic logic [34:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                          input logic s, input logic c);
        logic [63:0] mask, bb, ci, full, low;
        logic        co, cm;
        logic [31:0] r;
        mask = (64'd1 << w) - 64'd1;
        bb   = s ? (~{32'd0, b}) & mask : {32'd0, b} & mask;
        ci   = (s || c) ? 64'd1 : 64'd0;
        full = ({32'd0, a} & mask) + bb + ci;
        r    = 32'(full & mask);
        co   = full[w];
        low  = ({32'd0, a} & (mask >> 1)) + (bb & (mask >> 1)) + ci;
        cm   = low[w-1];
        return {(r == 32'd0), cm ^ co, co, r};
    endfunction

    // ---------------- (8,2) instance ----------------
    logic       a_iv = 1'b0, a_ir, a_sub = 1'b0, a_cin = 1'b0, a_ov, a_or = 1'b1, a_co, a_of, a_z;
    logic [7:0] a_op1 = 8'h00, a_op2 = 8'h00, a_res;

    pipelined_add_sub #(.WIDTH(8), .STAGES(2)) u_a (
        .CLK(clk), .RESET_N(rst_n), .in_valid(a_iv), .in_ready(a_ir),
        .op1(a_op1), .op2(a_op2), .sub(a_sub), .cin(a_cin),
        .out_valid(a_ov), .out_ready(a_or), .result(a_res),
        .carry(a_co), .overflow(a_of), .zero(a_z)
    );

    // ---------------- (16,4) instance ----------------
    logic        bp_iv = 1'b0, bp_ir, bp_sub = 1'b0, bp_cin = 1'b0, bp_ov, bp_or = 1'b1, bp_co, bp_of, bp_z;
    logic [15:0] bp_a = 16'h0, bp_b = 16'h0, bp_res;

    pipelined_add_sub #(.WIDTH(16), .STAGES(4)) u_bp (
        .CLK(clk), .RESET_N(rst_n), .in_valid(bp_iv), .in_ready(bp_ir),
        .op1(bp_a), .op2(bp_b), .sub(bp_sub), .cin(bp_cin),
        .out_valid(bp_ov), .out_ready(bp_or), .result(bp_res),
        .carry(bp_co), .overflow(bp_of), .zero(bp_z)
    );

    // ---------------- sweep instances ----------------
    logic        sw_iv = 1'b0, sw_or = 1'b1, sw_sub = 1'b0, sw_cin = 1'b0;
    logic [31:0] sw_a = 32'h0, sw_b = 32'h0;

    for (genvar g = 0; g < 3; g++) begin : sw
        localparam int W = (g == 2) ? 32 : 8;
        localparam int S = (g == 0) ? 1 : ((g == 1) ? 8 : 4);

        logic         ir, ov, co, of, ze;
        logic [W-1:0] r;
        logic [34:0]  exp_q[$];
        int           tin_q[$];
        int           last_stall = -1;
        int           n_out = 0;
        logic [34:0]  e;
        int           t;

        pipelined_add_sub #(.WIDTH(W), .STAGES(S)) u (
            .CLK(clk), .RESET_N(rst_n), .in_valid(sw_iv), .in_ready(ir),
            .op1(sw_a[W-1:0]), .op2(sw_b[W-1:0]), .sub(sw_sub), .cin(sw_cin),
            .out_valid(ov), .out_ready(sw_or), .result(r),
            .carry(co), .overflow(of), .zero(ze)
        );

        always @(negedge clk) begin
            if (rst_n) begin
                if (ov && sw_or) begin
                    if (exp_q.size() == 0) begin
                        chk($sformatf("sw%0d_spurious_out", g), 64'(ov), 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        t = tin_q.pop_front();
                        n_out++;
                        chk($sformatf("sw%0d_result", g), 64'(r), 64'(e[W-1:0]));
                        chk($sformatf("sw%0d_carry", g), 64'(co), 64'(e[32]));
                        chk($sformatf("sw%0d_overflow", g), 64'(of), 64'(e[33]));
                        chk($sformatf("sw%0d_zero", g), 64'(ze), 64'(e[34]));
                        if (last_stall < t)
                            chk($sformatf("sw%0d_latency", g), 64'(cyc_n - t), 64'(S));
                    end
                end
                if (ov && !sw_or) last_stall = cyc_n;
                if (sw_iv && ir) begin
                    exp_q.push_back(model(W, sw_a, sw_b, sw_sub, sw_cin));
                    tin_q.push_back(cyc_n);
                end
            end
        end
    end

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       s;
        logic       c;
        logic [7:0] r;
        logic       co;
        logic       ov;
        logic       z;
    } vec_t;

    vec_t        vecs[9];
    logic [34:0] bq[$];
    logic [34:0] be;
    logic [15:0] held_res;
    logic        held_co, held_of, held_z, held_v, acc;
    int          sent, got;

    initial begin
        vecs[0] = '{8'h3C, 8'h05, 1'b0, 1'b0, 8'h41, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{8'hFF, 8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{8'h05, 8'h07, 1'b1, 1'b0, 8'hFE, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{8'h10, 8'h10, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1};
        vecs[7] = '{8'hC0, 8'hC0, 1'b0, 1'b0, 8'h80, 1'b1, 1'b0, 1'b0};
        vecs[8] = '{8'h7F, 8'h7F, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b0};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(a_ov), 64'd0);
        chk("rst_result", 64'(a_res), 64'd0);
        chk("rst_carry", 64'(a_co), 64'd0);
        chk("rst_overflow", 64'(a_of), 64'd0);
        chk("rst_zero", 64'(a_z), 64'd0);
        chk("rst_in_ready", 64'(a_ir), 64'd1);
        chk("rst_bp_out_valid", 64'(bp_ov), 64'd0);
        rst_n = 1'b1;

        // Directed vectors, one at a time, latency 2
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
            a_iv = 1'b1; a_op1 = vecs[i].a; a_op2 = vecs[i].b; a_sub = vecs[i].s; a_cin = vecs[i].c;
            @(posedge clk); #1;
            a_iv = 1'b0;
            @(negedge clk);
            chk($sformatf("v%0d_early_valid", i), 64'(a_ov), 64'd0);
            @(negedge clk);
            chk($sformatf("v%0d_valid", i), 64'(a_ov), 64'd1);
            chk($sformatf("v%0d_result", i), 64'(a_res), 64'(vecs[i].r));
            chk($sformatf("v%0d_carry", i), 64'(a_co), 64'(vecs[i].co));
            chk($sformatf("v%0d_overflow", i), 64'(a_of), 64'(vecs[i].ov));
            chk($sformatf("v%0d_zero", i), 64'(a_z), 64'(vecs[i].z));
        end

        // Reset with two operations in flight
        @(posedge clk); #1;
        a_iv = 1'b1; a_op1 = 8'hFF; a_op2 = 8'h01; a_sub = 1'b0; a_cin = 1'b0;
        @(posedge clk); #1;
        a_op1 = 8'h22; a_op2 = 8'h11;
        @(posedge clk); #1;
        a_iv = 1'b0;
        chk("rstmid_pre_valid", 64'(a_ov), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rstmid_valid", 64'(a_ov), 64'd0);
        chk("rstmid_result", 64'(a_res), 64'd0);
        chk("rstmid_carry", 64'(a_co), 64'd0);
        chk("rstmid_zero", 64'(a_z), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("rstmid_stale_%0d", i), 64'(a_ov), 64'd0);
        end
        @(posedge clk); #1;
        a_iv = 1'b1; a_op1 = 8'h10; a_op2 = 8'h20;
        @(posedge clk); #1;
        a_iv = 1'b0;
        @(negedge clk);
        chk("rstmid_new_early", 64'(a_ov), 64'd0);
        @(negedge clk);
        chk("rstmid_new_valid", 64'(a_ov), 64'd1);
        chk("rstmid_new_result", 64'(a_res), 64'h30);

        // Backpressure on (16,4): 6 back-to-back ops, out_ready low for 3 cycles
        sent = 0; got = 0; held_v = 1'b0; acc = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            bp_or = !(c >= 5 && c < 8);
            if (sent < 6) begin
                if (!bp_iv || acc) begin
                    bp_a = 16'($urandom); bp_b = 16'($urandom);
                    bp_sub = 1'($urandom_range(0, 1)); bp_cin = 1'($urandom_range(0, 1));
                end
                bp_iv = 1'b1;
            end else begin
                bp_iv = 1'b0;
            end
            @(negedge clk);
            acc = bp_iv & bp_ir;
            if (bp_ov && !bp_or) begin
                chk("bp_in_ready_drop", 64'(bp_ir), 64'd0);
                if (held_v) begin
                    chk("bp_hold_result", 64'(bp_res), 64'(held_res));
                    chk("bp_hold_flags", 64'({bp_co, bp_of, bp_z}), 64'({held_co, held_of, held_z}));
                end
                held_v = 1'b1; held_res = bp_res; held_co = bp_co; held_of = bp_of; held_z = bp_z;
            end else begin
                held_v = 1'b0;
            end
            if (bp_ov && bp_or) begin
                if (bq.size() == 0) begin
                    chk("bp_spurious_out", 64'(bp_ov), 64'd0);
                end else begin
                    be = bq.pop_front();
                    got++;
                    chk($sformatf("bp%0d_result", got), 64'(bp_res), 64'(be[15:0]));
                    chk($sformatf("bp%0d_flags", got), 64'({bp_co, bp_of, bp_z}), 64'({be[32], be[33], be[34]}));
                end
            end
            if (acc) begin
                bq.push_back(model(16, {16'd0, bp_a}, {16'd0, bp_b}, bp_sub, bp_cin));
                sent++;
            end
        end
        chk("bp_count", 64'(got), 64'd6);

        // Random sweep with random in_valid / out_ready
        for (int c = 0; c < 2500; c++) begin
            @(posedge clk); #1;
            sw_iv  = ($urandom_range(0, 3) != 0);
            sw_or  = ($urandom_range(0, 3) != 0);
            sw_a   = $urandom;
            sw_b   = $urandom;
            sw_sub = 1'($urandom_range(0, 1));
            sw_cin = 1'($urandom_range(0, 1));
        end
        @(posedge clk); #1;
        sw_iv = 1'b0;
        sw_or = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("sw0_drained", 64'(sw[0].exp_q.size()), 64'd0);
        chk("sw1_drained", 64'(sw[1].exp_q.size()), 64'd0);
        chk("sw2_drained", 64'(sw[2].exp_q.size()), 64'd0);
        chk("sw0_enough_ops", 64'(sw[0].n_out >= 1000), 64'd1);
        chk("sw1_enough_ops", 64'(sw[1].n_out >= 1000), 64'd1);
        chk("sw2_enough_ops", 64'(sw[2].n_out >= 1000), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipelined_add_sub.md
Name: pipelined_add_sub

Overview:
- Parametrised, pipelined two's-complement adder/subtractor for the ALU datapath.
- Splits a WIDTH-bit operation into STAGES equal slices. One slice is resolved per pipeline stage, and the carry is registered between stages.
- Accepts one operation per cycle through a valid/ready handshake, with backpressure from the consumer.
- Produces the result together with carry, signed-overflow and zero flags for downstream flag logic.

Parameters:
- WIDTH, 8: operand/result width in bits. Must be ≥2 and an integer multiple of STAGES.
- STAGES, 2: number of pipeline stages, equal to the number of WIDTH/STAGES-bit slices. Legal range 1..WIDTH.

Ports:
- CLK  input  1  rising-edge clock
- RESET_N  input  1  asynchronous active-low reset
- in_valid  input  1  operands presented this cycle
- in_ready  output  1  block accepts operands this cycle
- op1  input  WIDTH  first operand
- op2  input  WIDTH  second operand
- sub  input  1  0: op1+op2+cin; 1: op1-op2 (ignores cin)
- cin  input  1  carry-in, used only when sub=0
- out_valid  output  1  result/flags valid
- out_ready  input  1  consumer accepts result this cycle
- result  output  WIDTH  sum/difference, modulo 2^WIDTH
- carry  output  1  carry out of MSB (for sub: 1 = no borrow)
- overflow  output  1  signed overflow
- zero  output  1  result == 0

Behaviour:
- Clock, reset and handshake:
  - One clock, CLK. RESET_N is asynchronous and active-low; while it is low, every stage-valid bit, out_valid, result, carry, overflow and zero are cleared to 0.
  - advance = !out_valid | out_ready. in_ready = advance, combinational.
  - Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
- Pipeline:
  - Stage k (k = 0..STAGES-1) owns slice bits [(k+1)*W/S-1 : k*W/S].
  - Stage 0 registers op1, op2 and the effective carry. When sub=1 the effective b is ~op2 and the effective carry is 1; when sub=0, b is op2 and the carry is cin.
  - Each stage adds its slice of op1, its slice of b and the incoming carry, registers the slice sum and carry-out, and forwards the unresolved upper operand bits.
  - The MSB carry-in is retained for the overflow computation.
- Advance and stall:
  - All stage registers, including valid bits, load only when advance=1. When advance=0 every stage holds; there is no bubble collapse.
  - When advance=1 and no input transfer occurs, a bubble (valid=0) enters stage 0.
- Latency: exactly STAGES cycles from input transfer to out_valid when out_ready stays high. Throughput is 1 operation/cycle.
- Flags, all registered and aligned with result:
  - carry = carry out of bit WIDTH-1.
  - overflow = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
  - zero = (result == 0).
- Output stability: while out_valid=1 and out_ready=0, result and the flags must not change. While out_valid=0, the output values are don't-care, but must be 0 after reset.
- Boundaries:
  - Simultaneous output transfer and input transfer on the same cycle is legal and sustains full throughput.
  - in_valid deasserted mid-stream produces gaps in out_valid, with order preserved.
  - RESET_N asserted mid-operation discards all in-flight operations immediately, with no partial output. The first operation after reset release exhibits the normal latency.
  - STAGES=1 degenerates to a single registered adder with latency 1.
  - Arithmetic is modulo 2^WIDTH; results wrap silently, with overflow and carry reporting the condition.

Test Plan:
- Basic add, WIDTH=8, STAGES=2, out_ready=1: op1=0x3C, op2=0x05, sub=0, cin=0 → after 2 cycles out_valid=1, result=0x41, carry=0, overflow=0, zero=0.
- Carry across slices and zero, WIDTH=8: 0xFF + 0x01, cin=0 → result=0x00, carry=1, overflow=0, zero=1. Repeat with cin=1 → result=0x01, zero=0.
- Subtract and overflow, WIDTH=8:
  - 0x80 - 0x01 → result=0x7F, carry=1, overflow=1.
  - 0x05 - 0x07 → result=0xFE, carry=0, overflow=0.
  - 0x7F + 0x01 → result=0x80, overflow=1.
- Backpressure, STAGES=4, WIDTH=16: stream 6 back-to-back random operations, hold out_ready=0 for 3 cycles mid-stream → in_ready drops the same cycle, held outputs stay stable, all 6 results emerge in order and match the reference model.
- Reset mid-operation: launch 2 operations, assert RESET_N low 1 cycle after the first transfer → all outputs read 0 immediately. After release, no stale out_valid appears; a new operation 0x10+0x20 returns 0x30 after STAGES cycles.
- Parameter sweep: (WIDTH, STAGES) ∈ {(8,1), (8,8), (32,4)} with 1000 random operations, random in_valid and out_ready → every result and flag matches the reference model, and latency equals STAGES whenever out_ready=1.
